// File: rtl/rst_ctrl_pkg.sv
// Shared encodings for the reset sequencer: FSM states, reset-cause codes and
// small elaboration/priority helpers.
package rst_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_ASSERT  = 2'b00,
      ST_RELEASE = 2'b01,
      ST_RUN     = 2'b10
   } rst_state_t;

   localparam logic [1:0] CAUSE_POR = 2'b00;
   localparam logic [1:0] CAUSE_EXT = 2'b01;
   localparam logic [1:0] CAUSE_WDT = 2'b10;
   localparam logic [1:0] CAUSE_SW  = 2'b11;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // Priority ext > wdt > sw when several requests coincide.
   function automatic logic [1:0] sel_cause(input logic ext_n, input logic wdt, input logic sw);
      if (!ext_n) begin
         return CAUSE_EXT;
      end else if (wdt) begin
         return CAUSE_WDT;
      end else if (sw) begin
         return CAUSE_SW;
      end else begin
         return CAUSE_POR;
      end
   endfunction

endpackage

// File: rtl/rst_ctrl_req_sync.sv
// Multi-flop synchronizer for the asynchronous active-low external reset request.
// Flops reset to the inactive (high) level.
module rst_ctrl_req_sync #(
   parameter int SYNC_LENGTH = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic async_req_n,
   output logic sync_req_n
);

   logic [SYNC_LENGTH-1:0] sync_r;

   // Shift the raw request through the synchronizer chain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_r <= '1;
      end else begin
         sync_r[0] <= async_req_n;
         for (int i = 1; i < SYNC_LENGTH; i++) begin
            sync_r[i] <= sync_r[i-1];
         end
      end
   end

   assign sync_req_n = sync_r[SYNC_LENGTH-1];

endmodule

// File: rtl/rst_ctrl_sequencer.sv
// Staged reset sequencer: holds all domains in reset, then releases them one by
// one in order, restarting on any external, watchdog or software request.
module rst_ctrl_sequencer
   import rst_ctrl_pkg::*;
#(
   parameter int NUM_STAGES  = 3,
   parameter int HOLD_CYCLES = 16,
   parameter int STAGE_GAP   = 8,
   parameter int SYNC_LENGTH = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  ext_rst_req_n,
   input  logic                  wdt_expired,
   input  logic                  sw_rst_req,
   output logic [NUM_STAGES-1:0] stage_rst_n,
   output logic                  busy,
   output logic                  rst_done,
   output logic [1:0]            rst_cause
);

   localparam int CNT_W = $clog2(max_int(HOLD_CYCLES, STAGE_GAP) + 1);
   localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
   localparam logic [CNT_W-1:0] HOLD_TC  = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_TC   = CNT_W'(STAGE_GAP - 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES - 1);

   logic                  ext_req_sync_n_s;
   logic                  req_s;
   logic [1:0]            req_cause_s;
   logic [IDX_W-1:0]      next_idx_s;

   rst_state_t            state_r;
   logic [CNT_W-1:0]      cnt_r;
   logic [IDX_W-1:0]      stage_idx_r;
   logic [NUM_STAGES-1:0] stage_rst_n_r;
   logic                  busy_r;
   logic                  rst_done_r;
   logic [1:0]            rst_cause_r;

   rst_ctrl_req_sync #(
      .SYNC_LENGTH(SYNC_LENGTH)
   ) u_req_sync (
      .clk        (clk),
      .rst_n      (rst_n),
      .async_req_n(ext_rst_req_n),
      .sync_req_n (ext_req_sync_n_s)
   );

   // Request decode and next stage index.
   always_comb begin
      req_s       = ~ext_req_sync_n_s | wdt_expired | sw_rst_req;
      req_cause_s = sel_cause(ext_req_sync_n_s, wdt_expired, sw_rst_req);
      next_idx_s  = stage_idx_r + IDX_W'(1);
   end

   // Sequencer FSM; a request from any state restarts the hold period with
   // the counter cleared, so the hold is measured from the last request cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r       <= ST_ASSERT;
         cnt_r         <= '0;
         stage_idx_r   <= '0;
         stage_rst_n_r <= '0;
         busy_r        <= 1'b1;
         rst_done_r    <= 1'b0;
         rst_cause_r   <= CAUSE_POR;
      end else begin
         rst_done_r <= 1'b0;
         if (req_s) begin
            state_r       <= ST_ASSERT;
            cnt_r         <= '0;
            stage_idx_r   <= '0;
            stage_rst_n_r <= '0;
            busy_r        <= 1'b1;
            rst_cause_r   <= req_cause_s;
         end else begin
            case (state_r)
               ST_ASSERT: begin
                  if (cnt_r == HOLD_TC) begin
                     cnt_r            <= '0;
                     stage_idx_r      <= '0;
                     stage_rst_n_r[0] <= 1'b1;
                     if (NUM_STAGES == 1) begin
                        state_r    <= ST_RUN;
                        busy_r     <= 1'b0;
                        rst_done_r <= 1'b1;
                     end else begin
                        state_r <= ST_RELEASE;
                     end
                  end else begin
                     cnt_r <= cnt_r + CNT_W'(1);
                  end
               end
               ST_RELEASE: begin
                  if (cnt_r == GAP_TC) begin
                     cnt_r                     <= '0;
                     stage_idx_r               <= next_idx_s;
                     stage_rst_n_r[next_idx_s] <= 1'b1;
                     if (next_idx_s == LAST_IDX) begin
                        state_r    <= ST_RUN;
                        busy_r     <= 1'b0;
                        rst_done_r <= 1'b1;
                     end else begin
                        state_r <= ST_RELEASE;
                     end
                  end else begin
                     cnt_r <= cnt_r + CNT_W'(1);
                  end
               end
               ST_RUN: begin
                  cnt_r <= '0;
               end
               default: begin
                  state_r       <= ST_ASSERT;
                  cnt_r         <= '0;
                  stage_idx_r   <= '0;
                  stage_rst_n_r <= '0;
                  busy_r        <= 1'b1;
               end
            endcase
         end
      end
   end

   assign stage_rst_n = stage_rst_n_r;
   assign busy        = busy_r;
   assign rst_done    = rst_done_r;
   assign rst_cause   = rst_cause_r;

endmodule

// File: tb/tb_rst_ctrl_sequencer.sv
// Directed bench for rst_ctrl_sequencer with NUM_STAGES=3, HOLD_CYCLES=16,
// STAGE_GAP=8, SYNC_LENGTH=2; expected release timing is derived by hand.
module tb_rst_ctrl_sequencer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ext_rst_req_n = 1'b1;
   logic       wdt_expired = 1'b0;
   logic       sw_rst_req = 1'b0;
   logic [2:0] stage_rst_n;
   logic       busy;
   logic       rst_done;
   logic [1:0] rst_cause;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   rst_ctrl_sequencer #(
      .NUM_STAGES (3),
      .HOLD_CYCLES(16),
      .STAGE_GAP  (8),
      .SYNC_LENGTH(2)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .ext_rst_req_n(ext_rst_req_n),
      .wdt_expired  (wdt_expired),
      .sw_rst_req   (sw_rst_req),
      .stage_rst_n  (stage_rst_n),
      .busy         (busy),
      .rst_done     (rst_done),
      .rst_cause    (rst_cause)
   );

   // Expected stage vector s edges after the edge on which all stages went low.
   function automatic logic [2:0] exp_stage(input int s);
      if (s < 16)      return 3'b000;
      else if (s < 24) return 3'b001;
      else if (s < 32) return 3'b011;
      else             return 3'b111;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (stage_rst_n !== 3'b000) begin n_fail++; $display("FAIL reset_stage got %b expected 000", stage_rst_n); end
      n_checks++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy got %b expected 1", busy); end
      n_checks++;
      if (rst_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b expected 0", rst_done); end
      n_checks++;
      if (rst_cause !== 2'b00) begin n_fail++; $display("FAIL reset_cause got %b expected 00", rst_cause); end
   endtask

   task automatic test_por();
      @(posedge clk);
      #1 rst_n = 1'b1;
      for (int e = 1; e <= 34; e++) begin
         step();
         n_checks++;
         if (stage_rst_n !== exp_stage(e)) begin n_fail++; $display("FAIL por_stage edge %0d got %b expected %b", e, stage_rst_n, exp_stage(e)); end
         n_checks++;
         if (busy !== (e < 32)) begin n_fail++; $display("FAIL por_busy edge %0d got %b expected %b", e, busy, (e < 32)); end
         n_checks++;
         if (rst_done !== (e == 32)) begin n_fail++; $display("FAIL por_done edge %0d got %b expected %b", e, rst_done, (e == 32)); end
         n_checks++;
         if (rst_cause !== 2'b00) begin n_fail++; $display("FAIL por_cause edge %0d got %b expected 00", e, rst_cause); end
      end
   endtask

   task automatic test_sw();
      int done_cnt = 0;
      repeat (3) step();
      sw_rst_req = 1'b1;
      step();
      sw_rst_req = 1'b0;
      n_checks++;
      if (stage_rst_n !== 3'b000 || busy !== 1'b1) begin n_fail++; $display("FAIL sw_assert got stage=%b busy=%b expected stage=000 busy=1", stage_rst_n, busy); end
      n_checks++;
      if (rst_cause !== 2'b11) begin n_fail++; $display("FAIL sw_cause got %b expected 11", rst_cause); end
      for (int s = 1; s <= 33; s++) begin
         step();
         if (rst_done === 1'b1) done_cnt++;
         n_checks++;
         if (stage_rst_n !== exp_stage(s)) begin n_fail++; $display("FAIL sw_stage +%0d got %b expected %b", s, stage_rst_n, exp_stage(s)); end
         n_checks++;
         if (rst_done !== (s == 32)) begin n_fail++; $display("FAIL sw_done +%0d got %b expected %b", s, rst_done, (s == 32)); end
         n_checks++;
         if (rst_cause !== 2'b11) begin n_fail++; $display("FAIL sw_cause_hold +%0d got %b expected 11", s, rst_cause); end
      end
      n_checks++;
      if (done_cnt != 1) begin n_fail++; $display("FAIL sw_done_count got %0d expected 1", done_cnt); end
   endtask

   task automatic test_priority();
      wdt_expired = 1'b1;
      sw_rst_req  = 1'b1;
      step();
      wdt_expired = 1'b0;
      sw_rst_req  = 1'b0;
      n_checks++;
      if (rst_cause !== 2'b10) begin n_fail++; $display("FAIL prio_cause got %b expected 10", rst_cause); end
      n_checks++;
      if (stage_rst_n !== 3'b000) begin n_fail++; $display("FAIL prio_stage got %b expected 000", stage_rst_n); end
      repeat (4) step();
      wdt_expired = 1'b1;
      step();
      wdt_expired = 1'b0;
      for (int s = 1; s <= 33; s++) begin
         step();
         n_checks++;
         if (stage_rst_n !== exp_stage(s)) begin n_fail++; $display("FAIL wdt_rehold_stage +%0d got %b expected %b", s, stage_rst_n, exp_stage(s)); end
         n_checks++;
         if (busy !== (s < 32)) begin n_fail++; $display("FAIL wdt_rehold_busy +%0d got %b expected %b", s, busy, (s < 32)); end
         n_checks++;
         if (rst_cause !== 2'b10) begin n_fail++; $display("FAIL wdt_rehold_cause +%0d got %b expected 10", s, rst_cause); end
      end
   endtask

   task automatic test_ext();
      sw_rst_req = 1'b1;
      step();
      sw_rst_req = 1'b0;
      repeat (26) step();
      n_checks++;
      if (stage_rst_n !== 3'b011) begin n_fail++; $display("FAIL ext_pre_stage got %b expected 011", stage_rst_n); end
      ext_rst_req_n = 1'b0;
      step();
      n_checks++;
      if (stage_rst_n !== 3'b011) begin n_fail++; $display("FAIL ext_sync1_stage got %b expected 011", stage_rst_n); end
      step();
      n_checks++;
      if (stage_rst_n !== 3'b011 || rst_cause !== 2'b11) begin n_fail++; $display("FAIL ext_sync2 got stage=%b cause=%b expected stage=011 cause=11", stage_rst_n, rst_cause); end
      step();
      n_checks++;
      if (stage_rst_n !== 3'b000 || busy !== 1'b1) begin n_fail++; $display("FAIL ext_assert got stage=%b busy=%b expected stage=000 busy=1", stage_rst_n, busy); end
      n_checks++;
      if (rst_cause !== 2'b01) begin n_fail++; $display("FAIL ext_cause got %b expected 01", rst_cause); end
      for (int i = 4; i <= 100; i++) begin
         step();
         n_checks++;
         if (stage_rst_n !== 3'b000 || busy !== 1'b1) begin n_fail++; $display("FAIL ext_hold +%0d got stage=%b busy=%b expected stage=000 busy=1", i, stage_rst_n, busy); end
      end
      ext_rst_req_n = 1'b1;
      for (int e = 1; e <= 34; e++) begin
         step();
         n_checks++;
         if (stage_rst_n !== exp_stage(e - 2)) begin n_fail++; $display("FAIL ext_release_stage +%0d got %b expected %b", e, stage_rst_n, exp_stage(e - 2)); end
         n_checks++;
         if (rst_done !== (e == 34)) begin n_fail++; $display("FAIL ext_release_done +%0d got %b expected %b", e, rst_done, (e == 34)); end
         n_checks++;
         if (rst_cause !== 2'b01) begin n_fail++; $display("FAIL ext_release_cause +%0d got %b expected 01", e, rst_cause); end
      end
   endtask

   task automatic test_async_rst();
      sw_rst_req = 1'b1;
      step();
      sw_rst_req = 1'b0;
      repeat (28) step();
      n_checks++;
      if (stage_rst_n !== 3'b011) begin n_fail++; $display("FAIL arst_pre_stage got %b expected 011", stage_rst_n); end
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if (stage_rst_n !== 3'b000 || busy !== 1'b1) begin n_fail++; $display("FAIL arst_immediate got stage=%b busy=%b expected stage=000 busy=1", stage_rst_n, busy); end
      n_checks++;
      if (rst_cause !== 2'b00 || rst_done !== 1'b0) begin n_fail++; $display("FAIL arst_cause got cause=%b done=%b expected cause=00 done=0", rst_cause, rst_done); end
      @(posedge clk);
      #1 rst_n = 1'b1;
      for (int e = 1; e <= 33; e++) begin
         step();
         n_checks++;
         if (stage_rst_n !== exp_stage(e)) begin n_fail++; $display("FAIL arst_seq_stage edge %0d got %b expected %b", e, stage_rst_n, exp_stage(e)); end
         n_checks++;
         if (rst_done !== (e == 32)) begin n_fail++; $display("FAIL arst_seq_done edge %0d got %b expected %b", e, rst_done, (e == 32)); end
         n_checks++;
         if (rst_cause !== 2'b00) begin n_fail++; $display("FAIL arst_seq_cause edge %0d got %b expected 00", e, rst_cause); end
      end
   endtask

   initial begin
      test_reset();
      test_por();
      test_sw();
      test_priority();
      test_ext();
      test_async_rst();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/rst_ctrl_sequencer.md
RST_CTRL_SEQUENCER -- requirements
Module: rst_ctrl_sequencer

Interface
REQ-001 Parameter NUM_STAGES, default 3: number of sequenced reset domains (1..8).
REQ-002 Parameter HOLD_CYCLES, default 16: minimum cycles all stages stay asserted (>=2).
REQ-003 Parameter STAGE_GAP, default 8: cycles between consecutive stage releases (>=1).
REQ-004 Parameter SYNC_LENGTH, default 2: synchronizer depth for ext_rst_req_n.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset (power-on / upstream synchronized reset).
REQ-007 ext_rst_req_n  in  1  asynchronous, active-low level reset request (e.g. pushbutton).
REQ-008 wdt_expired  in  1  synchronous one-cycle watchdog reset request.
REQ-009 sw_rst_req  in  1  synchronous one-cycle software reset request.
REQ-010 stage_rst_n  out  NUM_STAGES  active-low per-domain resets; bit 0 released first.
REQ-011 busy  out  1  high while any stage_rst_n bit is low.
REQ-012 rst_done  out  1  one-cycle pulse when the last stage is released.
REQ-013 rst_cause  out  2  cause of most recent sequence: 00 POR, 01 ext, 10 wdt, 11 sw.

Function
REQ-014 States: ASSERT (hold counter running), RELEASE (stage index and gap counter running), RUN.
REQ-015 ASSERT: all stage_rst_n low; after HOLD_CYCLES cycles in ASSERT, stage_rst_n[0] rises and state moves to RELEASE (stage index 0).
REQ-016 RELEASE: stage k rises STAGE_GAP cycles after stage k-1; stages never release out of order.
REQ-017 Stage NUM_STAGES-1 rises on the same edge on which busy falls, rst_done pulses for exactly one cycle, and state moves to RUN; with NUM_STAGES=1 this edge is the ASSERT exit edge.
REQ-018 A request is any of: synchronized ext_rst_req_n low, wdt_expired high, sw_rst_req high.
REQ-019 Request in RUN or RELEASE: on the next edge all stage_rst_n go low together, busy rises, state enters ASSERT with hold counter cleared.
REQ-020 Request in ASSERT: hold counter restarts at 0 (hold period is measured from the last request cycle).
REQ-021 Synchronized ext_rst_req_n held low: stay in ASSERT indefinitely; HOLD_CYCLES starts counting on the first cycle it reads high.
REQ-022 rst_cause updated on the edge a request is accepted; simultaneous requests prioritized ext > wdt > sw.
REQ-023 rst_cause changes only on request acceptance; it is stable throughout RELEASE and RUN.
REQ-024 ext_rst_req_n passes through a SYNC_LENGTH-flop synchronizer (reset to "request inactive") before use; its latency is excluded from HOLD_CYCLES.
REQ-025 Counters sized by $clog2 of max(HOLD_CYCLES, STAGE_GAP)+1; counters never wrap, they saturate at terminal count until the state changes.
REQ-026 All outputs are driven directly from flops; no combinational path from inputs to outputs.

Reset
REQ-027 rst_n low asynchronously forces: state ASSERT, counters 0, stage_rst_n all 0, busy 1, rst_done 0, rst_cause 00, synchronizer flops inactive.
REQ-028 rst_n low mid-sequence aborts immediately; after rst_n rises, the sequence restarts from ASSERT with the full HOLD_CYCLES.
REQ-029 rst_n rising is assumed synchronous to clk (release supplied by the upstream reset synchronizer).

Structure
REQ-030 State encoding and rst_cause encoding constants (CAUSE_POR/EXT/WDT/SW) reside in shared package rst_ctrl_pkg.
REQ-031 The ext_rst_req_n synchronizer is instantiated as one sub-module, rst_ctrl_req_sync (parameter SYNC_LENGTH); all remaining logic is in this module.

Verification (NUM_STAGES=3, HOLD_CYCLES=16, STAGE_GAP=8, SYNC_LENGTH=2)
REQ-032 rst_n released at edge 0 -> stage_rst_n 000 until edge 16; 001 at 16, 011 at 24, 111 at 32; busy falls and rst_done pulses at edge 32; rst_cause=00.
REQ-033 In RUN, sw_rst_req pulsed one cycle at edge N -> stage_rst_n=000 at N+1, rst_cause=11, 111 again at N+33, rst_done single pulse.
REQ-034 wdt_expired and sw_rst_req high in the same cycle -> rst_cause=10; second wdt_expired pulse 5 cycles into ASSERT -> release of stage 0 delayed to 16 cycles after that pulse.
REQ-035 ext_rst_req_n low for 100 cycles during RELEASE (after stage 1 release) -> all stages low 3 edges after assertion, held low while input low, stage 0 releases 16 cycles after synchronized input reads high; rst_cause=01.
REQ-036 rst_n pulsed low at edge 28 (stages 011) -> stage_rst_n=000 immediately (asynchronously), rst_cause=00, full 16/24/32 release sequence repeats from rst_n release.
